// File: rtl/branch_predict_unit_pkg.sv
// rtl/branch_predict_unit_pkg.sv - shared opcode/counter constants and branch condition helper
package branch_predict_unit_pkg;

    localparam logic [3:0] OP_BGT = 4'b1000;
    localparam logic [3:0] OP_BLT = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1010;
    localparam logic [3:0] OP_BNE = 4'b1011;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Operands are widened to this width by the caller (sign- or zero-extended
    // to match the comparison mode) so one function serves every DATA_W.
    localparam int CMP_W = 64;

    function automatic logic is_branch_op(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

    function automatic logic branch_cond(input logic [3:0] op,
                                         input logic [CMP_W-1:0] rd,
                                         input logic [CMP_W-1:0] rs,
                                         input logic signed_cmp);
        logic gt;
        logic lt;
        logic res;
        if (signed_cmp) begin
            gt = $signed(rd) > $signed(rs);
            lt = $signed(rd) < $signed(rs);
        end else begin
            gt = rd > rs;
            lt = rd < rs;
        end
        case (op)
            OP_BGT:  res = gt;
            OP_BLT:  res = lt;
            OP_BEQ:  res = (rd == rs);
            OP_BNE:  res = (rd != rs);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - fetch prediction and resolve/flush signal bundle
interface branch_predict_unit_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16
);
    logic [PC_W-1:0]   fetch_pc;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic              res_valid;
    logic [3:0]        res_opcode;
    logic [DATA_W-1:0] res_rd;
    logic [DATA_W-1:0] res_rs;
    logic [DATA_W-1:0] res_imm;
    logic [PC_W-1:0]   res_pc;
    logic              res_pred_taken;
    logic [PC_W-1:0]   res_pred_target;
    logic              flush;
    logic [PC_W-1:0]   redirect_pc;
    logic              branch_taken;

    modport master (
        output fetch_pc, res_valid, res_opcode, res_rd, res_rs, res_imm, res_pc,
               res_pred_taken, res_pred_target,
        input  pred_taken, pred_target, flush, redirect_pc, branch_taken
    );

    modport slave (
        input  fetch_pc, res_valid, res_opcode, res_rd, res_rs, res_imm, res_pc,
               res_pred_taken, res_pred_target,
        output pred_taken, pred_target, flush, redirect_pc, branch_taken
    );
endinterface

// File: rtl/branch_predict_unit_branch_compare.sv
// rtl/branch_predict_unit_branch_compare.sv - opcode/operand to actual branch outcome
import branch_predict_unit_pkg::*;

module branch_compare #(
    parameter int DATA_W     = 16,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] rd,
    input  logic [DATA_W-1:0] rs,
    output logic              taken
);
    logic [CMP_W-1:0] rd_ext;
    logic [CMP_W-1:0] rs_ext;

    // Widen operands in the same mode as the compare, then evaluate the condition
    always_comb begin
        if (SIGNED_CMP) begin
            rd_ext = CMP_W'($signed(rd));
            rs_ext = CMP_W'($signed(rs));
        end else begin
            rd_ext = CMP_W'(rd);
            rs_ext = CMP_W'(rs);
        end
        taken = branch_cond(opcode, rd_ext, rs_ext, SIGNED_CMP);
    end
endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - branch resolve, BTB prediction and mispredict flush
import branch_predict_unit_pkg::*;

module branch_predict_unit #(
    parameter int DATA_W     = 16,
    parameter int PC_W       = 16,
    parameter int BTB_DEPTH  = 16,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    branch_predict_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = PC_W - IDX_W;

    logic             btb_valid  [BTB_DEPTH];
    logic [TAG_W-1:0] btb_tag    [BTB_DEPTH];
    logic [PC_W-1:0]  btb_target [BTB_DEPTH];
    logic [1:0]       btb_ctr    [BTB_DEPTH];

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             fetch_hit;

    logic [IDX_W-1:0] res_idx;
    logic [TAG_W-1:0] res_tag;
    logic             res_hit;
    logic             res_is_branch;
    logic             res_taken;
    logic [PC_W-1:0]  imm_pc;
    logic [PC_W-1:0]  res_target;
    logic [PC_W-1:0]  res_next_pc;
    logic             mispredict;
    logic             accept;

    logic             flush_q;
    logic [PC_W-1:0]  redirect_q;
    logic             taken_q;

    assign fetch_idx = bus.fetch_pc[IDX_W-1:0];
    assign fetch_tag = bus.fetch_pc[PC_W-1:IDX_W];
    assign res_idx   = bus.res_pc[IDX_W-1:0];
    assign res_tag   = bus.res_pc[PC_W-1:IDX_W];

    branch_compare #(
        .DATA_W     (DATA_W),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_compare (
        .opcode (bus.res_opcode),
        .rd     (bus.res_rd),
        .rs     (bus.res_rs),
        .taken  (res_taken)
    );

    // Fetch-side lookup: reads the registered BTB, so same-cycle updates are not seen
    always_comb begin
        fetch_hit       = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
        bus.pred_taken  = fetch_hit && btb_ctr[fetch_idx][1];
        bus.pred_target = fetch_hit ? btb_target[fetch_idx] : bus.fetch_pc + PC_W'(1);
    end

    // Resolve-side evaluation of the actual path and the mispredict decision
    always_comb begin
        res_is_branch = is_branch_op(bus.res_opcode);
        res_hit       = btb_valid[res_idx] && (btb_tag[res_idx] == res_tag);
        imm_pc        = PC_W'($signed(bus.res_imm));
        res_target    = bus.res_pc + imm_pc;
        res_next_pc   = res_taken ? res_target : bus.res_pc + PC_W'(1);
        mispredict    = (bus.res_pred_taken != res_taken) ||
                        (res_taken && (bus.res_pred_target != res_target));
        // While flush is high the resolve stage holds a wrong-path instruction
        accept        = bus.res_valid && !flush_q;
    end

    // Registered flush/redirect and last branch outcome
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_q    <= 1'b0;
            redirect_q <= '0;
            taken_q    <= 1'b0;
        end else begin
            flush_q <= accept && mispredict;
            if (accept) begin
                redirect_q <= res_next_pc;
            end
            if (accept && res_is_branch) begin
                taken_q <= res_taken;
            end
        end
    end

    // BTB training: counter/target update on hit, allocate on taken miss, drop aliases
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= CTR_WNT;
            end
        end else if (accept) begin
            if (res_is_branch) begin
                if (res_hit) begin
                    if (res_taken) begin
                        btb_ctr[res_idx]    <= (btb_ctr[res_idx] == CTR_ST) ? CTR_ST
                                               : btb_ctr[res_idx] + 2'd1;
                        btb_target[res_idx] <= res_target;
                    end else begin
                        btb_ctr[res_idx]    <= (btb_ctr[res_idx] == CTR_SNT) ? CTR_SNT
                                               : btb_ctr[res_idx] - 2'd1;
                    end
                end else if (res_taken) begin
                    btb_valid[res_idx]  <= 1'b1;
                    btb_tag[res_idx]    <= res_tag;
                    btb_target[res_idx] <= res_target;
                    btb_ctr[res_idx]    <= CTR_WT;
                end
            end else if (res_hit) begin
                btb_valid[res_idx] <= 1'b0;
            end
        end
    end

    assign bus.flush        = flush_q;
    assign bus.redirect_pc  = redirect_q;
    assign bus.branch_taken = taken_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed bench with behavioural BTB model and per-cycle compare
module tb_branch_predict_unit;
    import branch_predict_unit_pkg::*;

    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    branch_predict_unit_if #(.DATA_W(16), .PC_W(16)) bus0 ();
    branch_predict_unit_if #(.DATA_W(16), .PC_W(16)) bus1 ();

    branch_predict_unit #(.DATA_W(16), .PC_W(16), .BTB_DEPTH(DEPTH), .SIGNED_CMP(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    branch_predict_unit #(.DATA_W(16), .PC_W(16), .BTB_DEPTH(DEPTH), .SIGNED_CMP(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of bus0 (unsigned compare): BTB as plain int arrays
    bit m_valid  [DEPTH];
    int m_tag    [DEPTH];
    int m_target [DEPTH];
    int m_ctr    [DEPTH];
    bit m_flush;
    int m_redirect;
    bit m_btaken;

    always @(posedge clk or posedge reset) begin : model
        int pc, idx, tg, a, b, tgt, nxt;
        bit br, tk, mis, acc, hit;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_valid[i]  <= 1'b0;
                m_tag[i]    <= 0;
                m_target[i] <= 0;
                m_ctr[i]    <= 1;
            end
            m_flush    <= 1'b0;
            m_redirect <= 0;
            m_btaken   <= 1'b0;
        end else begin
            acc = (bus0.res_valid === 1'b1) && !m_flush;
            pc  = int'(bus0.res_pc);
            idx = pc % DEPTH;
            tg  = pc / DEPTH;
            a   = int'(bus0.res_rd);
            b   = int'(bus0.res_rs);
            br  = (bus0.res_opcode >= 4'd8) && (bus0.res_opcode <= 4'd11);
            case (bus0.res_opcode)
                4'd8:    tk = a > b;
                4'd9:    tk = a < b;
                4'd10:   tk = a == b;
                4'd11:   tk = a != b;
                default: tk = 1'b0;
            endcase
            tgt = (pc + int'($signed(bus0.res_imm))) & 32'hFFFF;
            nxt = tk ? tgt : (pc + 1) & 32'hFFFF;
            mis = (bus0.res_pred_taken != tk) || (tk && int'(bus0.res_pred_target) != tgt);
            hit = m_valid[idx] && (m_tag[idx] == tg);
            m_flush <= acc && mis;
            if (acc && mis) m_redirect <= nxt;
            if (acc && br) m_btaken <= tk;
            if (acc && br && hit && tk) begin
                m_ctr[idx]    <= (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
                m_target[idx] <= tgt;
            end else if (acc && br && hit && !tk) begin
                m_ctr[idx] <= (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
            end else if (acc && br && !hit && tk) begin
                m_valid[idx]  <= 1'b1;
                m_tag[idx]    <= tg;
                m_target[idx] <= tgt;
                m_ctr[idx]    <= 2;
            end else if (acc && !br && hit) begin
                m_valid[idx] <= 1'b0;
            end
        end
    end

    // Compare bus0 outputs against the model every mid-cycle outside reset
    always @(negedge clk) begin : compare
        int fpc, fidx;
        bit fhit;
        if (!reset) begin
            fpc  = int'(bus0.fetch_pc);
            fidx = fpc % DEPTH;
            fhit = m_valid[fidx] && (m_tag[fidx] == fpc / DEPTH);
            check("model_pred_taken", bus0.pred_taken, fhit && (m_ctr[fidx] >= 2));
            check("model_pred_target", bus0.pred_target,
                  fhit ? m_target[fidx] : (fpc + 1) & 32'hFFFF);
            check("model_flush", bus0.flush, m_flush);
            if (m_flush) check("model_redirect_pc", bus0.redirect_pc, m_redirect);
            check("model_branch_taken", bus0.branch_taken, m_btaken);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic res(input logic [3:0] op, input logic [15:0] rd, input logic [15:0] rs,
                       input logic [15:0] imm, input logic [15:0] pc,
                       input logic pt, input logic [15:0] ptg);
        bus0.res_valid       = 1'b1;
        bus0.res_opcode      = op;
        bus0.res_rd          = rd;
        bus0.res_rs          = rs;
        bus0.res_imm         = imm;
        bus0.res_pc          = pc;
        bus0.res_pred_taken  = pt;
        bus0.res_pred_target = ptg;
    endtask

    task automatic idle();
        bus0.res_valid = 1'b0;
        bus1.res_valid = 1'b0;
    endtask

    initial begin
        bus0.fetch_pc = '0; bus0.res_valid = 1'b0; bus0.res_opcode = '0; bus0.res_rd = '0;
        bus0.res_rs = '0; bus0.res_imm = '0; bus0.res_pc = '0; bus0.res_pred_taken = 1'b0;
        bus0.res_pred_target = '0;
        bus1.fetch_pc = '0; bus1.res_valid = 1'b0; bus1.res_opcode = '0; bus1.res_rd = '0;
        bus1.res_rs = '0; bus1.res_imm = '0; bus1.res_pc = '0; bus1.res_pred_taken = 1'b0;
        bus1.res_pred_target = '0;

        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        bus0.fetch_pc = 16'h0005;
        @(negedge clk);
        check("rst_pred_taken", bus0.pred_taken, 0);
        check("rst_pred_target", bus0.pred_target, 16'h0006);
        check("rst_flush", bus0.flush, 0);
        check("rst_redirect", bus0.redirect_pc, 0);
        check("rst_branch_taken", bus0.branch_taken, 0);

        // First beq: taken but predicted not taken -> flush, allocate ctr=10
        cyc();
        res(OP_BEQ, 16'h0007, 16'h0007, 16'h0004, 16'h0010, 1'b0, 16'h0011);
        cyc(); idle(); bus0.fetch_pc = 16'h0010;
        @(negedge clk);
        check("beq1_flush", bus0.flush, 1);
        check("beq1_redirect", bus0.redirect_pc, 16'h0014);
        check("beq1_taken", bus0.branch_taken, 1);
        check("beq1_pred_taken", bus0.pred_taken, 1);
        check("beq1_pred_target", bus0.pred_target, 16'h0014);
        cyc();

        // Three correctly predicted taken resolves: ctr 10->11->11->11
        for (int k = 0; k < 3; k++) begin
            res(OP_BEQ, 16'h0007, 16'h0007, 16'h0004, 16'h0010, 1'b1, 16'h0014);
            cyc(); idle();
            @(negedge clk);
            check("beq_hit_flush", bus0.flush, 0);
            check("beq_hit_pred_taken", bus0.pred_taken, 1);
        end

        // Not taken with taken prediction: ctr 11->10, still predicts taken
        res(OP_BEQ, 16'h0007, 16'h0008, 16'h0004, 16'h0010, 1'b1, 16'h0014);
        cyc(); idle();
        @(negedge clk);
        check("beq_nt_flush", bus0.flush, 1);
        check("beq_nt_redirect", bus0.redirect_pc, 16'h0011);
        check("beq_nt_taken", bus0.branch_taken, 0);
        check("beq_nt_pred_taken", bus0.pred_taken, 1);
        cyc();

        // blt 0xFFFF < 0x0001: unsigned not taken, signed taken
        res(OP_BLT, 16'hFFFF, 16'h0001, 16'h0005, 16'h0020, 1'b0, 16'h0021);
        bus1.res_valid = 1'b1; bus1.res_opcode = OP_BLT; bus1.res_rd = 16'hFFFF;
        bus1.res_rs = 16'h0001; bus1.res_imm = 16'h0005; bus1.res_pc = 16'h0020;
        bus1.res_pred_taken = 1'b0; bus1.res_pred_target = 16'h0021;
        cyc(); idle();
        @(negedge clk);
        check("blt_u_flush", bus0.flush, 0);
        check("blt_u_taken", bus0.branch_taken, 0);
        check("blt_s_flush", bus1.flush, 1);
        check("blt_s_redirect", bus1.redirect_pc, 16'h0025);
        check("blt_s_taken", bus1.branch_taken, 1);

        // bne target wraps past 0xFFFF
        res(OP_BNE, 16'h0001, 16'h0002, 16'h0003, 16'hFFFE, 1'b0, 16'hFFFF);
        cyc(); idle();
        @(negedge clk);
        check("bne_wrap_flush", bus0.flush, 1);
        check("bne_wrap_redirect", bus0.redirect_pc, 16'h0001);
        cyc();

        // Aliasing: 0x0003 allocated, 0x0013 shares the index but misses
        res(OP_BEQ, 16'h0005, 16'h0005, 16'h0002, 16'h0003, 1'b0, 16'h0004);
        cyc(); idle(); bus0.fetch_pc = 16'h0003;
        @(negedge clk);
        check("alias_alloc_redirect", bus0.redirect_pc, 16'h0005);
        check("alias_alloc_pred", bus0.pred_taken, 1);
        #1 bus0.fetch_pc = 16'h0013;
        #1 check("alias_miss_pred", bus0.pred_taken, 0);
        check("alias_miss_target", bus0.pred_target, 16'h0014);
        cyc();
        res(4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 1'b1, 16'h0005);
        cyc(); idle(); bus0.fetch_pc = 16'h0003;
        @(negedge clk);
        check("nonbr_flush", bus0.flush, 1);
        check("nonbr_redirect", bus0.redirect_pc, 16'h0004);
        check("nonbr_taken_kept", bus0.branch_taken, 1);
        check("nonbr_inval_pred", bus0.pred_taken, 0);
        check("nonbr_inval_target", bus0.pred_target, 16'h0004);
        cyc();

        // Back-to-back: second mispredicting branch arrives while flush is high
        res(OP_BEQ, 16'h0001, 16'h0001, 16'h0001, 16'h0030, 1'b0, 16'h0031);
        cyc();
        res(OP_BNE, 16'h0001, 16'h0002, 16'h0008, 16'h0040, 1'b0, 16'h0041);
        @(negedge clk);
        check("b2b_first_flush", bus0.flush, 1);
        check("b2b_first_redirect", bus0.redirect_pc, 16'h0031);
        cyc(); idle(); bus0.fetch_pc = 16'h0040;
        @(negedge clk);
        check("b2b_no_second_flush", bus0.flush, 0);
        check("b2b_taken_kept", bus0.branch_taken, 1);
        check("b2b_btb_unchanged", bus0.pred_taken, 0);
        check("b2b_btb_target", bus0.pred_target, 16'h0041);
        cyc();

        // Reset asserted while flush is high
        res(OP_BEQ, 16'h0002, 16'h0002, 16'h0006, 16'h0050, 1'b0, 16'h0051);
        cyc(); idle(); bus0.fetch_pc = 16'h0050;
        @(negedge clk);
        check("mid_flush_before", bus0.flush, 1);
        #1 reset = 1'b1;
        #1;
        check("mid_flush_dropped", bus0.flush, 0);
        check("mid_flush_pred", bus0.pred_taken, 0);
        check("mid_flush_redirect", bus0.redirect_pc, 0);
        check("mid_flush_taken", bus0.branch_taken, 0);
        check("mid_flush_target", bus0.pred_target, 16'h0051);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("post_reset_flush", bus0.flush, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
